// File: rtl/random_gen_mc.sv
// Masking-randomness source: per-bit XNOR LFSRs XORed with a hybrid 90/150 CASR, behind a
// warm-up phase and a valid/ready output register. Define RANDOM_GEN_HEALTH_EN for the repetition test.
module random_gen_mc #(
    parameter int unsigned  W         = 16,
    parameter int unsigned  LFSR_N    = 17,
    parameter logic [127:0] SEED_LFSR = 128'h5149fc7f_2ee4ce28_9689fea9_adff284c,
    parameter logic [127:0] SEED_CASR = 128'h6ce7bb42_4bb2e05f_88a74b4a_70e6e72d,
    parameter int unsigned  WARMUP    = 32,
    parameter int unsigned  REP_LIMIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         seed_valid_i,
    output logic         seed_ready_o,
    input  logic [31:0]  seed_data_i,
    output logic [W-1:0] rand_o,
    output logic         rand_valid_o,
    input  logic         rand_ready_i,
    output logic         health_fail_o
);

    localparam int unsigned C     = W + 5;
    localparam int unsigned TAP   = (LFSR_N == 17) ? 14 : 3;
    localparam int unsigned CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {StWarmup, StRun} state_e;

    function automatic logic [LFSR_N-1:0] lfsr_init(input int unsigned i);
        logic [LFSR_N-1:0] v;
        for (int b = 0; b < LFSR_N; b++) v[b] = SEED_LFSR[(b + 17 * i) % 128];
        if (&v) v = '0;
        return v;
    endfunction

    function automatic logic [C-1:0] casr_init();
        logic [C-1:0] c;
        c = SEED_CASR[C-1:0];
        if (c == '0) c = C'(1);
        return c;
    endfunction

    function automatic logic [LFSR_N-1:0] lfsr_step(input logic [LFSR_N-1:0] v);
        return {v[LFSR_N-2:0], ~(v[LFSR_N-1] ^ v[TAP-1])};
    endfunction

    // Null boundaries fall out of the shifts; the middle cell adds itself (rule 150).
    function automatic logic [C-1:0] casr_step(input logic [C-1:0] c);
        logic [C-1:0] n;
        n = (c << 1) ^ (c >> 1);
        n[C/2] = n[C/2] ^ c[C/2];
        return n;
    endfunction

    function automatic logic [LFSR_N-1:0] seed_slice(input logic [31:0] s, input int unsigned i);
        logic [LFSR_N-1:0] r;
        for (int b = 0; b < LFSR_N; b++) r[b] = s[(b + i) % 32];
        return r;
    endfunction

    function automatic logic [C-1:0] seed_repeat(input logic [31:0] s);
        logic [C-1:0] r;
        for (int j = 0; j < C; j++) r[j] = s[j % 32];
        return r;
    endfunction

    logic [LFSR_N-1:0] lfsr_q [W];
    logic [LFSR_N-1:0] lfsr_d [W];
    logic [C-1:0]      casr_q, casr_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      rand_q, rand_d, word;
    logic              rand_valid_q, rand_valid_d;
    logic              seed_ready_q;
    logic              seed_fire, load, blocked;

`ifdef RANDOM_GEN_HEALTH_EN
    localparam int unsigned REP_W = (REP_LIMIT > 2) ? $clog2(REP_LIMIT) : 1;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             have_prev_q, have_prev_d;
    logic             health_fail_q, health_fail_d;
    assign blocked = health_fail_q;
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        seed_fire = seed_valid_i & seed_ready_q;
        for (int i = 0; i < W; i++) begin
            lfsr_d[i] = lfsr_step(lfsr_q[i]);
            if (seed_fire) begin
                lfsr_d[i] = lfsr_d[i] ^ seed_slice(seed_data_i, i);
                if (&lfsr_d[i]) lfsr_d[i] = '0;
            end
        end
        casr_d = casr_step(casr_q);
        if (seed_fire) begin
            casr_d = casr_d ^ seed_repeat(seed_data_i);
            if (casr_d == '0) casr_d = C'(1);
        end
        for (int i = 0; i < W; i++) word[i] = lfsr_q[i][LFSR_N-1] ^ casr_q[i];

        state_d      = state_q;
        cnt_d        = cnt_q;
        rand_d       = rand_q;
        rand_valid_d = rand_valid_q;
        load         = (state_q == StRun) && (!rand_valid_q || rand_ready_i) && !blocked;
`ifdef RANDOM_GEN_HEALTH_EN
        rep_d         = rep_q;
        have_prev_d   = have_prev_q;
        health_fail_d = health_fail_q;
`endif
        unique case (state_q)
            StWarmup: begin
                if (cnt_q == CNT_W'(WARMUP - 1)) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRun: begin
                if (load) begin
                    rand_d       = word;
                    rand_valid_d = 1'b1;
`ifdef RANDOM_GEN_HEALTH_EN
                    rep_d       = (have_prev_q && word == rand_q) ? rep_q + REP_W'(1) : '0;
                    have_prev_d = 1'b1;
                    if (rep_d == REP_W'(REP_LIMIT - 1)) begin
                        health_fail_d = 1'b1;
                        rand_valid_d  = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StWarmup;
        endcase

        // A handshake on the same edge has already delivered the old word; drop everything else.
        if (seed_fire) begin
            state_d      = StWarmup;
            cnt_d        = '0;
            rand_d       = rand_q;
            rand_valid_d = 1'b0;
`ifdef RANDOM_GEN_HEALTH_EN
            rep_d         = '0;
            have_prev_d   = 1'b0;
            health_fail_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < W; i++) lfsr_q[i] <= lfsr_init(i);
            casr_q       <= casr_init();
            state_q      <= StWarmup;
            cnt_q        <= '0;
            rand_q       <= '0;
            rand_valid_q <= 1'b0;
            seed_ready_q <= 1'b0;
`ifdef RANDOM_GEN_HEALTH_EN
            rep_q         <= '0;
            have_prev_q   <= 1'b0;
            health_fail_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < W; i++) lfsr_q[i] <= lfsr_d[i];
            casr_q       <= casr_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rand_q       <= rand_d;
            rand_valid_q <= rand_valid_d;
            seed_ready_q <= 1'b1;
`ifdef RANDOM_GEN_HEALTH_EN
            rep_q         <= rep_d;
            have_prev_q   <= have_prev_d;
            health_fail_q <= health_fail_d;
`endif
        end
    end

    assign seed_ready_o = seed_ready_q;
    assign rand_o       = rand_q;
    assign rand_valid_o = rand_valid_q;
`ifdef RANDOM_GEN_HEALTH_EN
    assign health_fail_o = health_fail_q;
`else
    assign health_fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_random_gen_mc.sv
// Directed bench for random_gen_mc: bit-level reference model of the generators plus
// scenario tasks for warm-up latency, stalls, reseeding, mid-stream reset and the health test.
module tb_random_gen_mc;

    localparam logic [127:0] SEED_L = 128'h5149fc7f_2ee4ce28_9689fea9_adff284c;
    localparam logic [127:0] SEED_C = 128'h6ce7bb42_4bb2e05f_88a74b4a_70e6e72d;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_h_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic        rand_ready = 1'b0;
    logic [31:0] seed_data = '0;
    logic        seed_ready, rand_valid, health_fail;
    logic [15:0] rand_w;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    random_gen_mc u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .seed_valid_i (seed_valid),
        .seed_ready_o (seed_ready),
        .seed_data_i  (seed_data),
        .rand_o       (rand_w),
        .rand_valid_o (rand_valid),
        .rand_ready_i (rand_ready),
        .health_fail_o(health_fail)
    );

`ifdef RANDOM_GEN_HEALTH_EN
    logic       seed_ready_h, rand_valid_h, health_fail_h;
    logic [0:0] rand_h;

    random_gen_mc #(.W(1), .LFSR_N(5), .WARMUP(4), .REP_LIMIT(4)) u_dut_h (
        .clk_i        (clk),
        .rst_ni       (rst_h_n),
        .seed_valid_i (seed_valid),
        .seed_ready_o (seed_ready_h),
        .seed_data_i  (seed_data),
        .rand_o       (rand_h),
        .rand_valid_o (rand_valid_h),
        .rand_ready_i (rand_ready),
        .health_fail_o(health_fail_h)
    );
`endif

    // Reference model state, written bit by bit
    logic [16:0] m_lfsr [64];
    logic [68:0] m_casr;
    int          m_w, m_n, m_c;
    logic [63:0] exp_pre;
    bit          rdy_exp;
    bit          sel_h;
    logic [15:0] first_words [8];

    task automatic m_init(input int w, input int n);
        logic [16:0] v;
        bit all;
        m_w = w; m_n = n; m_c = w + 5;
        for (int i = 0; i < 64; i++) m_lfsr[i] = '0;
        for (int i = 0; i < w; i++) begin
            v = '0; all = 1'b1;
            for (int b = 0; b < n; b++) begin
                v[b] = SEED_L[(b + 17 * i) % 128];
                if (!v[b]) all = 1'b0;
            end
            m_lfsr[i] = all ? 17'd0 : v;
        end
        m_casr = '0;
        for (int j = 0; j < m_c; j++) m_casr[j] = SEED_C[j];
        if (m_casr == '0) m_casr[0] = 1'b1;
    endtask

    task automatic m_step();
        logic [16:0] v;
        logic [68:0] nc;
        logic fb, bt;
        for (int i = 0; i < m_w; i++) begin
            v  = m_lfsr[i];
            fb = ~(v[m_n-1] ^ v[(m_n == 17) ? 13 : 2]);
            for (int b = 16; b > 0; b--) v[b] = v[b-1];
            v[0] = fb;
            for (int b = m_n; b < 17; b++) v[b] = 1'b0;
            m_lfsr[i] = v;
        end
        nc = '0;
        for (int j = 0; j < m_c; j++) begin
            bt = 1'b0;
            if (j > 0) bt = bt ^ m_casr[j-1];
            if (j < m_c - 1) bt = bt ^ m_casr[j+1];
            if (j == m_c / 2) bt = bt ^ m_casr[j];
            nc[j] = bt;
        end
        m_casr = nc;
    endtask

    task automatic m_reseed(input logic [31:0] s);
        bit all;
        for (int i = 0; i < m_w; i++) begin
            all = 1'b1;
            for (int b = 0; b < m_n; b++) begin
                m_lfsr[i][b] = m_lfsr[i][b] ^ s[(b + i) % 32];
                if (!m_lfsr[i][b]) all = 1'b0;
            end
            if (all) m_lfsr[i] = '0;
        end
        for (int j = 0; j < m_c; j++) m_casr[j] = m_casr[j] ^ s[j % 32];
        if (m_casr == '0) m_casr[0] = 1'b1;
    endtask

    function automatic logic [63:0] m_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < m_w; i++) w[i] = m_lfsr[i][m_n-1] ^ m_casr[i];
        return w;
    endfunction

    // One clock edge; exp_pre holds the word a load on this edge must produce.
    task automatic tick();
        logic r;
        bit fire;
        r = sel_h ? rst_h_n : rst_n;
        fire = seed_valid && rdy_exp;
        exp_pre = m_word();
        @(posedge clk);
        if (!r) begin
            m_init(m_w, m_n);
            rdy_exp = 1'b0;
        end else begin
            m_step();
            if (fire) m_reseed(seed_data);
            rdy_exp = 1'b1;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (rand_w !== 16'h0 || rand_valid !== 1'b0 || seed_ready !== 1'b0 || health_fail !== 1'b0) begin
            errors++;
            $display("FAIL %s: rand=%h valid=%b seed_ready=%b hf=%b, want 0000 0 0 0",
                     tag, rand_w, rand_valid, seed_ready, health_fail);
        end
    endtask

    task automatic test_reset();
        sel_h = 1'b0; rst_n = 1'b0; seed_valid = 1'b0; rand_ready = 1'b1;
        m_init(16, 17);
        repeat (3) tick();
        check_reset_outputs("reset");
    endtask

    // Release from reset, check warm-up latency and the stream that follows.
    task automatic test_warmup_stream(input bit replay, input int nwords);
        rst_n = 1'b1; rand_ready = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 1) begin
                vectors++;
                if (seed_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL seed_ready after first edge: got %b want 1", seed_ready);
                end
            end
            vectors++;
            if (e < 33 && rand_valid !== 1'b0) begin
                errors++;
                $display("FAIL warmup edge %0d: rand_valid=%b want 0", e, rand_valid);
            end else if (e == 33 && (rand_valid !== 1'b1 || rand_w !== exp_pre[15:0])) begin
                errors++;
                $display("FAIL first word: valid=%b rand=%h want 1 %h", rand_valid, rand_w, exp_pre[15:0]);
            end
        end
        for (int k = 0; k < nwords; k++) begin
            if (k < 8 && !replay) first_words[k] = rand_w;
            if (k < 8 && replay) begin
                vectors++;
                if (rand_w !== first_words[k]) begin
                    errors++;
                    $display("FAIL replay word %0d: got %h want %h", k, rand_w, first_words[k]);
                end
            end
            tick();
            vectors++;
            if (rand_valid !== 1'b1 || rand_w !== exp_pre[15:0] || health_fail !== 1'b0) begin
                errors++;
                $display("FAIL stream word %0d: valid=%b rand=%h hf=%b want 1 %h 0",
                         k, rand_valid, rand_w, health_fail, exp_pre[15:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        held = rand_w;
        rand_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (rand_valid !== 1'b1 || rand_w !== held) begin
                errors++;
                $display("FAIL stall cycle %0d: valid=%b rand=%h want 1 %h", k, rand_valid, rand_w, held);
            end
        end
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (rand_valid !== 1'b1 || rand_w !== exp_pre[15:0]) begin
                errors++;
                $display("FAIL post-stall word %0d: valid=%b rand=%h want 1 %h",
                         k, rand_valid, rand_w, exp_pre[15:0]);
            end
        end
    endtask

    task automatic test_reseed_handshake();
        vectors++;
        if (rand_valid !== 1'b1) begin
            errors++;
            $display("FAIL reseed handshake precondition: valid=%b want 1", rand_valid);
        end
        seed_valid = 1'b1; seed_data = 32'hDEADBEEF;
        tick();
        seed_valid = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            tick();
            vectors++;
            if (e < 33 && rand_valid !== 1'b0) begin
                errors++;
                $display("FAIL reseed warmup edge %0d: valid=%b want 0", e, rand_valid);
            end else if (e == 33 && (rand_valid !== 1'b1 || rand_w !== exp_pre[15:0])) begin
                errors++;
                $display("FAIL reseed first word: valid=%b rand=%h want 1 %h", rand_valid, rand_w, exp_pre[15:0]);
            end
        end
        for (int k = 0; k < 50; k++) begin
            tick();
            vectors++;
            if (rand_valid !== 1'b1 || rand_w !== exp_pre[15:0]) begin
                errors++;
                $display("FAIL reseeded word %0d: valid=%b rand=%h want 1 %h",
                         k, rand_valid, rand_w, exp_pre[15:0]);
            end
        end
    endtask

    task automatic test_reseed_warmup();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        seed_valid = 1'b1; seed_data = 32'h01234567;
        tick();
        seed_valid = 1'b0;
        n = 0;
        while (rand_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 33 || rand_w !== exp_pre[15:0]) begin
            errors++;
            $display("FAIL warmup reseed latency: edges=%0d rand=%h want 33 %h", n, rand_w, exp_pre[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid reset");
        test_warmup_stream(1'b1, 20);
    endtask

    task automatic test_health();
`ifdef RANDOM_GEN_HEALTH_EN
        int  wcnt, rep;
        bit  run, valid, fail, have_prev;
        logic w, prev;
        sel_h = 1'b1; rand_ready = 1'b1; seed_valid = 1'b0;
        m_init(1, 5);
        rst_h_n = 1'b0;
        repeat (2) tick();
        rst_h_n = 1'b1;
        wcnt = 0; rep = 0; run = 0; valid = 0; fail = 0; have_prev = 0; prev = 1'b0; w = 1'b0;
        for (int e = 0; e < 400 && !fail; e++) begin
            tick();
            if (!run) begin
                if (wcnt == 3) begin run = 1; wcnt = 0; end
                else wcnt++;
            end else begin
                w = exp_pre[0];
                rep = (have_prev && w == prev) ? rep + 1 : 0;
                prev = w; have_prev = 1; valid = 1;
                if (rep == 3) begin fail = 1; valid = 0; end
            end
            vectors++;
            if (health_fail_h !== fail || rand_valid_h !== valid || (valid && rand_h !== w)) begin
                errors++;
                $display("FAIL health edge %0d: hf=%b valid=%b rand=%b want %b %b %b",
                         e, health_fail_h, rand_valid_h, rand_h, fail, valid, w);
            end
        end
        vectors++;
        if (!fail) begin
            errors++;
            $display("FAIL health trip: no run of 4 within budget, hf=%b want 1", health_fail_h);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (health_fail_h !== 1'b1 || rand_valid_h !== 1'b0) begin
                errors++;
                $display("FAIL health blocked %0d: hf=%b valid=%b want 1 0", k, health_fail_h, rand_valid_h);
            end
        end
        seed_valid = 1'b1; seed_data = 32'h00000005;
        tick();
        seed_valid = 1'b0;
        vectors++;
        if (health_fail_h !== 1'b0 || rand_valid_h !== 1'b0) begin
            errors++;
            $display("FAIL health clear: hf=%b valid=%b want 0 0", health_fail_h, rand_valid_h);
        end
        sel_h = 1'b0;
`else
        tick();
        vectors++;
        if (health_fail !== 1'b0) begin
            errors++;
            $display("FAIL health tied off: hf=%b want 0", health_fail);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup_stream(1'b0, 1000);
        test_stall();
        test_reseed_handshake();
        test_reseed_warmup();
        test_reset_mid();
        test_health();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
